// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory req/ack handshakes and wait timeout; define MCC_PERF_CNT_EN to add the retired_cnt output
module multicycle_controller #(
  parameter int ALUOP_W   = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic               alu_zero,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               alu_src,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               trap
`ifdef MCC_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt
`endif
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [2:0] {C_NONE, C_LOAD, C_STORE, C_OPIMM, C_OP, C_BRANCH} class_e;
  state_e               state_q, state_d;
  class_e               class_q, class_d, dec_class;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 waiting, ack, timeout, is_mem, uses_imm;
  logic [1:0]           class_op;
  assign dec_class = opcode == 7'b0000011 ? C_LOAD   :
                     opcode == 7'b0100011 ? C_STORE  :
                     opcode == 7'b0010011 ? C_OPIMM  :
                     opcode == 7'b0110011 ? C_OP     :
                     opcode == 7'b1100011 ? C_BRANCH : C_NONE;
  assign waiting  = state_q == S_FETCH || state_q == S_MEM;
  assign ack      = state_q == S_FETCH ? imem_ack : dmem_ack;
  assign timeout  = waiting && !ack && (cnt_q + TIMEOUT_W'(1)) == {TIMEOUT_W{1'b1}};
  assign is_mem   = class_q == C_LOAD || class_q == C_STORE;
  assign uses_imm = is_mem || class_q == C_OPIMM;
  assign class_op = is_mem ? 2'b01 : class_q == C_OP ? 2'b10 : class_q == C_BRANCH ? 2'b11 : 2'b00;
  // State, latched class and wait counter; reset returns to FETCH with no class
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      class_q <= C_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      cnt_q   <= cnt_d;
    end
  end
  // Sequence instruction phases; a stalled FETCH/MEM reaching the wait limit diverts to TRAP unless acked that cycle
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH:  state_d = imem_ack ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      S_DECODE: begin
        class_d = dec_class;
        state_d = dec_class == C_NONE ? S_TRAP : S_EXEC;
      end
      S_EXEC:   state_d = is_mem ? S_MEM : class_q == C_BRANCH ? S_FETCH : S_WB;
      S_MEM:    state_d = dmem_ack ? (class_q == C_LOAD ? S_WB : S_FETCH) : timeout ? S_TRAP : S_MEM;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
    cnt_d = waiting && !ack && state_d == state_q ? cnt_q + TIMEOUT_W'(1) : '0;
  end
  // Moore decode of state and latched class; every output is forced low while reset is held
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = '0;
    trap       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ack;
        end
        S_EXEC: begin
          alu_op   = ALUOP_W'(class_op);
          alu_src  = uses_imm;
          pc_write = class_q == C_BRANCH;
          pc_src   = class_q == C_BRANCH && alu_zero;
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          alu_src   = 1'b1;
          alu_op    = ALUOP_W'(2'b01);
          mem_read  = class_q == C_LOAD;
          mem_write = class_q == C_STORE;
          pc_write  = dmem_ack && class_q == C_STORE;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = class_q == C_LOAD;
          pc_write   = 1'b1;
          alu_op     = ALUOP_W'(class_op);
          alu_src    = uses_imm;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end
`ifdef MCC_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  assign retired_d   = pc_write ? retired_q + 32'd1 : retired_q;
  assign retired_cnt = rst_n ? retired_q : '0;
  // Count retirements, one per pc_write pulse, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) retired_q <= '0;
    else retired_q <= retired_d;
  end
`endif
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle main decoder for the RISC-V core. A state machine sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, with req/ack handshakes to instruction and data memory. It adds a per-access memory timeout, branch support and a trap state for illegal opcodes. It sits between the IR/PC registers and the datapath muxes, ALU control and register file.

Parameters:
ALUOP_W, 2, width of alu_op; must be >=2; codes are zero-extended into it.
TIMEOUT_W, 8, width of the memory-wait counter; timeout after 2**TIMEOUT_W-1 un-acked cycles.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
opcode  in  7  IR[6:0]; sampled in DECODE only.
alu_zero  in  1  ALU zero flag; sampled in EXEC of a branch.
imem_ack  in  1  instruction fetch complete.
dmem_ack  in  1  data access complete.
imem_req  out  1  instruction fetch request.
dmem_req  out  1  data access request.
ir_write  out  1  IR load enable.
pc_write  out  1  PC update enable.
pc_src  out  1  0 = PC+4, 1 = branch target.
alu_src  out  1  0 = rs2, 1 = immediate.
mem_to_reg  out  1  write-back selects memory data.
reg_write  out  1  register-file write enable.
mem_read  out  1  data read.
mem_write  out  1  data write.
alu_op  out  ALUOP_W  00 = add (OP-IMM), 01 = add (load/store), 10 = R-type funct, 11 = branch compare.
trap  out  1  sticky fault flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. While rst_n=0 at a rising edge: state<=FETCH, class<=NONE, counter<=0, trap<=0. All outputs read 0 during any cycle with rst_n=0.
- Output timing: outputs are Moore, decoded from the state and the latched class register. No output depends combinationally on opcode.
- FETCH: imem_req=1.
  - imem_ack=1: ir_write=1 in the same cycle; next state DECODE.
  - Otherwise the counter increments.
- DECODE: latch class from opcode. 0000011 LOAD, 0100011 STORE, 0010011 OPIMM, 0110011 OP, 1100011 BRANCH.
  - Legal class: next state EXEC.
  - Any other opcode: next state TRAP.
- EXEC: alu_op per class; alu_src=1 for LOAD/STORE/OPIMM, else 0.
  - LOAD/STORE: next state MEM.
  - OP/OPIMM: next state WB.
  - BRANCH: pc_write=1 and pc_src=alu_zero this cycle; next state FETCH (retire).
- MEM: dmem_req=1, alu_src=1, alu_op=01. mem_read=1 for LOAD; mem_write=1 for STORE.
  - dmem_ack with LOAD: next state WB.
  - dmem_ack with STORE: pc_write=1, pc_src=0; next state FETCH.
- WB: reg_write=1; mem_to_reg=1 only for LOAD; pc_write=1, pc_src=0; next state FETCH.
- TRAP: trap=1, all other outputs 0. Exit only via reset.
- Memory timeout: the counter clears on entering FETCH or MEM and on any ack. If the counter reaches 2**TIMEOUT_W-1 without an ack, the next state is TRAP. An ack in that same cycle wins over the timeout.
- pc_write: asserted exactly one cycle per retired instruction; never in FETCH, DECODE or TRAP.
- Latency with zero-wait memory: OP/OPIMM 4 cycles, BRANCH 3, STORE 4, LOAD 5.
- Reset mid-operation: a pending request is dropped immediately. A late ack arriving after reset counts only if the FSM is in FETCH/MEM.
- Spurious inputs: acks in states that do not request are ignored.

Optional Feature:
Macro MCC_PERF_CNT_EN.
- Defined: adds output retired_cnt (32 bits), cleared by reset. It increments on every cycle where pc_write=1 and wraps modulo 2**32.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- R-type, zero wait: opcode=0110011, acks immediate -> states F,D,E,W. In WB: reg_write=1, alu_op=10, alu_src=0, pc_write=1 for one cycle. 4 cycles total.
- Load with dmem_ack delayed 3 cycles: opcode=0000011 -> mem_read=1 and dmem_req=1 for 4 cycles. In WB: mem_to_reg=1, reg_write=1. 8 cycles total.
- Branch: opcode=1100011, alu_zero=1 -> EXEC has pc_write=1, pc_src=1, alu_op=11. Repeat with alu_zero=0 -> pc_src=0, reg_write never set.
- Illegal opcode 1111111 -> TRAP after DECODE; trap=1 held for 20 cycles. rst_n=0 for one edge -> trap=0, FETCH.
- TIMEOUT_W=3, imem_ack held 0 -> TRAP after 7 request cycles. Repeat with ack in the 7th cycle -> DECODE, no trap.
- Reset during MEM of a store -> mem_write and dmem_req at 0 the cycle after the edge. With MCC_PERF_CNT_EN: 3 retired instructions -> retired_cnt=3.
